test_mark_sched: RTL
====================

# test_mark_sched

Programmable test-pulse scheduler driven by the 20 MHz timing generator's 1 µs strobe and 1 s test mark. Once armed, it waits for the next second mark, then emits a burst of `cfg_rep` test pulses on `tst_out`. Each pulse has a programmable delay from the mark, a width and a repetition period, all counted in 1 µs ticks. It runs in the `clk20mhz` domain between the timing generator and the stand's test-signal outputs, and gives the control logic a busy/done handshake.

## Interface
- `CNT_W`, 16: width of the delay, width and period counters (µs ticks).
- `REP_W`, 8: width of the repetition counter.
- `clk20mhz`  in  1  system clock, 20 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `t1us`  in  1  1 µs strobe level from the timing generator, synchronous to `clk20mhz`.
- `sec_mark`  in  1  1 s test mark level, synchronous to `clk20mhz`.
- `cfg_delay`  in  CNT_W  µs ticks from the second mark to the first pulse.
- `cfg_width`  in  CNT_W  pulse high time in µs ticks; must be ≥1.
- `cfg_period`  in  CNT_W  pulse-start to pulse-start spacing in µs ticks.
- `cfg_rep`  in  REP_W  number of pulses; must be ≥1.
- `arm`  in  1  single-cycle request to start a sequence.
- `abort`  in  1  single-cycle cancel; this port exists only with `SCHED_ABORT_EN`.
- `busy`  out  1  high from arm acceptance until `done`.
- `done`  out  1  single-cycle completion strobe.
- `tst_out`  out  1  registered test pulse output.
- `err_cfg`  out  1  single-cycle strobe: `arm` was rejected because of invalid configuration.
- `err_overrun`  out  1  sticky flag: a second mark arrived during DELAY, PULSE or GAP.

## Operation
- Edge detection: `us_tick = t1us & ~t1us_q` and `sec_edge = sec_mark & ~sec_mark_q`. Both use a one-cycle registered copy of the input.
- FSM states: IDLE, WAIT_SEC, DELAY, PULSE, GAP, DONE.
- IDLE, `arm` high:
  - `cfg_width==0` or `cfg_rep==0`: stay in IDLE and pulse `err_cfg`.
  - Otherwise: latch all `cfg_*` into shadow registers, set `rep_left=cfg_rep`, clear `err_overrun`, go to WAIT_SEC.
  - `arm` outside IDLE is ignored.
- WAIT_SEC, `sec_edge`: go to PULSE with `cnt=width` if delay==0; otherwise go to DELAY with `cnt=delay`.
- DELAY: each `us_tick` decrements `cnt`. The tick that sees `cnt==1` moves to PULSE and loads `cnt=width`.
- PULSE: `tst_out=1`. Each `us_tick` decrements `cnt`. The tick that sees `cnt==1` decrements `rep_left`.
  - If `rep_left` becomes 0, go to DONE.
  - Otherwise go to GAP with `cnt = (period>width) ? period-width : 1`.
- GAP: `tst_out=0`. The tick that sees `cnt==1` moves to PULSE and loads `cnt=width`.
- DONE: `done=1` for one cycle, then go to IDLE.
- A `sec_edge` in DELAY, PULSE or GAP is ignored for sequencing and sets `err_overrun`.
- Counter arithmetic is unsigned, CNT_W bits. The subtraction `period-width` is evaluated only when `period>width`, so it never wraps.
- `us_tick` and `sec_edge` in the same cycle while in WAIT_SEC: only the state transition happens; that tick is not counted.

## Timing
- Reset values: `busy=0`, `done=0`, `tst_out=0`, `err_cfg=0`, `err_overrun=0`, state IDLE, all counters 0.
- `busy` rises the cycle after an accepted `arm`. It falls in the same cycle that `done` is high.
- `err_cfg` is high the cycle after a rejected `arm`.
- `sec_mark` rise to `tst_out` rise with delay==0: 2 cycles (edge register, then FSM/output register).
- With delay D>0, `tst_out` rises 1 cycle after the D-th `us_tick` that follows the edge.
- Pulse high time is exactly W `us_tick` strobes. With ticks aligned to the pulse start this is W×20 cycles.
- Pulse starts are `max(period, width+1)` ticks apart.
- `done` is asserted 1 cycle after `tst_out` falls for the last pulse.
- A reset assertion mid-sequence forces `tst_out=0` and all outputs to their reset values asynchronously.

## Configuration
- `SCHED_ABORT_EN` defined:
  - `abort` port present.
  - `abort` in any state other than IDLE forces `tst_out=0` next cycle, goes to DONE and pulses `done`.
  - `abort` and `arm` together in IDLE: `abort` wins and `arm` is ignored.
- `SCHED_ABORT_EN` undefined: no `abort` port; a sequence always runs to completion.

## Structure
- Shared package `tmark_pkg`: FSM state typedef/encoding, the default `CNT_W`/`REP_W` constants, and the constant `TICKS_PER_US=20`.
- One natural sub-module `tmark_edge`: a registered rising-edge detector, instantiated twice (for `t1us` and `sec_mark`).

## Test plan
- Arm with delay=3, width=2, period=5, rep=3, ticks every 20 cycles, then one mark. Expect three `tst_out` pulses of 40 cycles each, starts 100 cycles apart, first start 3 ticks + 1 cycle after the mark edge, then one `done` and `busy=0`.
- Arm with delay=0, width=1, rep=1. Expect `tst_out` high 2 cycles after the `sec_mark` rise, for one tick, followed by `done`.
- Arm with width=0, then with rep=0. Expect `err_cfg` each time, `busy` staying 0, `tst_out` staying 0.
- Arm with period=2, width=4, rep=2. Expect the gap clamped to 1 tick; pulse starts 5 ticks apart.
- Second `sec_mark` during the PULSE state. Expect `err_overrun=1` and the sequence unaffected; the next accepted `arm` clears `err_overrun`.
- With `SCHED_ABORT_EN`, `abort` mid-pulse, then `rst_n` low mid-DELAY on a second run. Expect `tst_out=0` and `done` after the abort; after the reset all outputs at 0 with no pending `done`.

Source files
------------

// File: rtl/tmark_pkg.sv
// Shared types and constants for the test-mark pulse scheduler.
// Optional abort support is controlled by the SCHED_ABORT_EN macro in the interface and top.
`timescale 1ns/1ps
package tmark_pkg;

   localparam int CNT_W_DEF    = 16;
   localparam int REP_W_DEF    = 8;
   localparam int TICKS_PER_US = 20;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_SEC = 3'd1,
      ST_DELAY    = 3'd2,
      ST_PULSE    = 3'd3,
      ST_GAP      = 3'd4,
      ST_DONE     = 3'd5
   } tmark_state_e;

endpackage

// File: rtl/test_mark_sched_if.sv
// Control-side bundle of the test-mark scheduler: configuration, arm and status handshake.
// The abort signal exists only when SCHED_ABORT_EN is defined.
`timescale 1ns/1ps
interface test_mark_sched_if
   import tmark_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int REP_W = REP_W_DEF
);

   logic [CNT_W-1:0] cfg_delay;
   logic [CNT_W-1:0] cfg_width;
   logic [CNT_W-1:0] cfg_period;
   logic [REP_W-1:0] cfg_rep;
   logic             arm;
`ifdef SCHED_ABORT_EN
   logic             abort;
`endif
   logic             busy;
   logic             done;
   logic             err_cfg;
   logic             err_overrun;

   modport master (
`ifdef SCHED_ABORT_EN
      output abort,
`endif
      output cfg_delay, cfg_width, cfg_period, cfg_rep, arm,
      input  busy, done, err_cfg, err_overrun
   );

   modport slave (
`ifdef SCHED_ABORT_EN
      input  abort,
`endif
      input  cfg_delay, cfg_width, cfg_period, cfg_rep, arm,
      output busy, done, err_cfg, err_overrun
   );

endinterface

// File: rtl/tmark_edge.sv
// Registered rising-edge detector: the strobe appears one cycle after the input is first seen high.
`timescale 1ns/1ps
module tmark_edge (
   input  logic clk20mhz,
   input  logic rst_n,
   input  logic sig,
   output logic rise
);

   logic sig_q;

   always_ff @(posedge clk20mhz or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sig_q <= sig;
         rise  <= sig & ~sig_q;
      end
   end

endmodule

// File: rtl/test_mark_sched.sv
// Test-pulse scheduler: after arm, waits for a second mark, then emits cfg_rep pulses timed in 1 us ticks.
// Define SCHED_ABORT_EN to add the abort input that cancels a running sequence.
`timescale 1ns/1ps
module test_mark_sched
   import tmark_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int REP_W = REP_W_DEF
) (
   input  logic             clk20mhz,
   input  logic             rst_n,
   input  logic             t1us,
   input  logic             sec_mark,
   test_mark_sched_if.slave ctl,
   output logic             tst_out
);

   logic             us_tick;
   logic             sec_edge;
   tmark_state_e     state;
   logic [CNT_W-1:0] cnt;
   logic [REP_W-1:0] rep_left;
   logic [CNT_W-1:0] delay_sh;
   logic [CNT_W-1:0] width_sh;
   logic [CNT_W-1:0] period_sh;
   logic             abort_req;
   logic             cfg_ok;
   logic             arm_take;
   logic             cnt_last;
   logic             rep_last;

   tmark_edge u_tick_edge (
      .clk20mhz (clk20mhz),
      .rst_n    (rst_n),
      .sig      (t1us),
      .rise     (us_tick)
   );

   tmark_edge u_sec_edge (
      .clk20mhz (clk20mhz),
      .rst_n    (rst_n),
      .sig      (sec_mark),
      .rise     (sec_edge)
   );

`ifdef SCHED_ABORT_EN
   assign abort_req = ctl.abort;
`else
   assign abort_req = 1'b0;
`endif

   // Gap between pulses; clamped to one tick so a pulse never merges with the next
   function automatic logic [CNT_W-1:0] gap_load(input logic [CNT_W-1:0] period,
                                                 input logic [CNT_W-1:0] width);
      if (period > width) return period - width;
      else                return CNT_W'(1);
   endfunction

   assign cfg_ok   = (ctl.cfg_width != '0) && (ctl.cfg_rep != '0);
   assign arm_take = (state == ST_IDLE) && ctl.arm && !abort_req;
   assign cnt_last = (cnt == CNT_W'(1));
   assign rep_last = (rep_left == REP_W'(1));

   always_ff @(posedge clk20mhz) begin
      if (arm_take && cfg_ok) begin
         delay_sh  <= ctl.cfg_delay;
         width_sh  <= ctl.cfg_width;
         period_sh <= ctl.cfg_period;
      end
   end

   always_ff @(posedge clk20mhz or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         rep_left        <= '0;
         tst_out         <= 1'b0;
         ctl.busy        <= 1'b0;
         ctl.done        <= 1'b0;
         ctl.err_cfg     <= 1'b0;
         ctl.err_overrun <= 1'b0;
      end else begin
         ctl.done    <= 1'b0;
         ctl.err_cfg <= 1'b0;
         if (abort_req && (state != ST_IDLE) && (state != ST_DONE)) begin
            state   <= ST_DONE;
            tst_out <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (arm_take) begin
                     if (!cfg_ok) begin
                        ctl.err_cfg <= 1'b1;
                     end else begin
                        rep_left        <= ctl.cfg_rep;
                        ctl.err_overrun <= 1'b0;
                        ctl.busy        <= 1'b1;
                        state           <= ST_WAIT_SEC;
                     end
                  end
               end
               // A tick coinciding with the mark is deliberately not counted here
               ST_WAIT_SEC: begin
                  if (sec_edge) begin
                     if (delay_sh == '0) begin
                        state   <= ST_PULSE;
                        cnt     <= width_sh;
                        tst_out <= 1'b1;
                     end else begin
                        state <= ST_DELAY;
                        cnt   <= delay_sh;
                     end
                  end
               end
               ST_DELAY: begin
                  if (sec_edge) ctl.err_overrun <= 1'b1;
                  if (us_tick) begin
                     if (cnt_last) begin
                        state   <= ST_PULSE;
                        cnt     <= width_sh;
                        tst_out <= 1'b1;
                     end else begin
                        cnt <= cnt - CNT_W'(1);
                     end
                  end
               end
               ST_PULSE: begin
                  if (sec_edge) ctl.err_overrun <= 1'b1;
                  if (us_tick) begin
                     if (cnt_last) begin
                        rep_left <= rep_left - REP_W'(1);
                        tst_out  <= 1'b0;
                        if (rep_last) begin
                           state <= ST_DONE;
                        end else begin
                           state <= ST_GAP;
                           cnt   <= gap_load(period_sh, width_sh);
                        end
                     end else begin
                        cnt <= cnt - CNT_W'(1);
                     end
                  end
               end
               ST_GAP: begin
                  if (sec_edge) ctl.err_overrun <= 1'b1;
                  if (us_tick) begin
                     if (cnt_last) begin
                        state   <= ST_PULSE;
                        cnt     <= width_sh;
                        tst_out <= 1'b1;
                     end else begin
                        cnt <= cnt - CNT_W'(1);
                     end
                  end
               end
               ST_DONE: begin
                  ctl.done <= 1'b1;
                  ctl.busy <= 1'b0;
                  state    <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
